dbg_bus_bridge: RTL and testbench

- Serial-driven debug bus initiator for the 6502 SoC; the other end of the memory/peripheral bus from the RAM/ROM/GPIO/ACIA responders.
- Accepts command bytes from a byte-wide UART receiver, requests the bus from the CPU, and performs reads/writes with the same AB/DO/WE/DI timing the CPU uses.
- Returns results through a byte-wide transmitter handshake.
- Used for program load, memory peek/poke, and block dump without halting the ROM flow.

---
 rtl/dbg_bus_bridge_pkg.sv | 39 +++
 rtl/dbg_bus_bridge_if.sv | 27 ++
 rtl/dbg_bus_bridge.sv | 179 +++++++++++++++++
 tb/tb_dbg_bus_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_bus_bridge_pkg.sv
// rtl/dbg_bus_bridge_pkg.sv - command/response codes, state and op encodings for the debug bus bridge
package dbg_bus_bridge_pkg;

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] CMD_B   = 8'h42;
  localparam logic [7:0] RSP_OK  = 8'h2E;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h21;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_ARG,
    ST_REQ,
    ST_BUS_ADDR,
    ST_BUS_WAIT,
    ST_RESP,
    ST_NEXT
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_W,
    OP_R,
    OP_B
  } op_e;

  function automatic op_e decode_cmd(input logic [7:0] b);
    case (b)
      CMD_W:   return OP_W;
      CMD_R:   return OP_R;
      CMD_B:   return OP_B;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dbg_bus_bridge_if.sv
// rtl/dbg_bus_bridge_if.sv - byte rx/tx handshake plus CPU-style AB/DO/WE/DI bus for the debug bridge
interface dbg_bus_bridge_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, bus_gnt, DI,
    output tx_data, tx_valid, bus_req, AB, DO, WE, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, bus_gnt, DI,
    input  tx_data, tx_valid, bus_req, AB, DO, WE, busy
  );

endinterface

// File: rtl/dbg_bus_bridge.sv
// rtl/dbg_bus_bridge.sv - serial-driven debug bus initiator (W/R/B commands)
// Optional DBG_TIMEOUT_EN: abort a partial command after TIMEOUT_CYCLES idle cycles.
module dbg_bus_bridge
  import dbg_bus_bridge_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dbg_bus_bridge_if.master  bus
);

  localparam logic [1:0] RdLat = 2'(READ_LATENCY);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  op_e         rx_op;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  txd_q, txd_d;
  logic [1:0]  lat_q, lat_d;
  logic        more_bytes;
  logic        tmo_hit;

`ifdef DBG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_q;
  logic            collect;

  assign collect = (state_q == ST_ADDR_HI) || (state_q == ST_ADDR_LO) || (state_q == ST_ARG);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (!collect || bus.rx_valid) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end

  assign tmo_hit = collect && !bus.rx_valid && (tmo_q == TmoLast);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  // Blocks hold the bus across the inter-byte RESP/NEXT gap; only the last byte releases it.
  assign more_bytes = (op_q == OP_B) && (cnt_q != 8'd0);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    txd_d        = txd_q;
    lat_d        = lat_q;
    rx_op        = decode_cmd(bus.rx_data);
    bus.bus_req  = 1'b0;
    bus.AB       = 16'h0000;
    bus.DO       = 8'h00;
    bus.WE       = 1'b0;
    bus.tx_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          op_d = rx_op;
          if (rx_op == OP_NONE) begin
            txd_d   = RSP_BAD;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ADDR_HI;
          end
        end
      end
      ST_ADDR_HI, ST_ADDR_LO, ST_ARG: begin
        if (tmo_hit) begin
          op_d    = OP_NONE;
          txd_d   = RSP_TMO;
          state_d = ST_RESP;
        end else if (bus.rx_valid) begin
          if (state_q == ST_ADDR_HI) begin
            addr_d[15:8] = bus.rx_data;
            state_d      = ST_ADDR_LO;
          end else if (state_q == ST_ADDR_LO) begin
            addr_d[7:0] = bus.rx_data;
            cnt_d       = 8'd0;
            state_d     = (op_q == OP_R) ? ST_REQ : ST_ARG;
          end else begin
            data_d  = bus.rx_data;
            cnt_d   = (op_q == OP_B) ? bus.rx_data : 8'd0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        bus.bus_req = 1'b1;
        if (bus.bus_gnt) begin
          state_d = ST_BUS_ADDR;
        end
      end
      ST_BUS_ADDR: begin
        bus.bus_req = 1'b1;
        if (bus.bus_gnt) begin
          bus.AB = addr_q;
          if (op_q == OP_W) begin
            bus.DO  = data_q;
            bus.WE  = 1'b1;
            txd_d   = RSP_OK;
            state_d = ST_RESP;
          end else begin
            lat_d   = 2'd1;
            state_d = ST_BUS_WAIT;
          end
        end
      end
      ST_BUS_WAIT: begin
        bus.bus_req = 1'b1;
        // Losing the grant mid-read restarts the address phase so DI is never sampled stale.
        if (!bus.bus_gnt) begin
          state_d = ST_BUS_ADDR;
        end else begin
          bus.AB = addr_q;
          if (lat_q == RdLat) begin
            txd_d   = bus.DI;
            state_d = ST_RESP;
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
      end
      ST_RESP: begin
        bus.tx_valid = 1'b1;
        bus.bus_req  = more_bytes;
        if (bus.tx_ready) begin
          state_d = more_bytes ? ST_NEXT : ST_IDLE;
        end
      end
      ST_NEXT: begin
        bus.bus_req = 1'b1;
        addr_d      = addr_q + 16'd1;
        cnt_d       = cnt_q - 8'd1;
        state_d     = ST_BUS_ADDR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.tx_data = txd_q;
  assign bus.busy    = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      addr_q  <= 16'h0000;
      data_q  <= 8'h00;
      cnt_q   <= 8'h00;
      txd_q   <= 8'h00;
      lat_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      lat_q   <= lat_d;
    end
  end

endmodule

// File: tb/tb_dbg_bus_bridge.sv
// tb/tb_dbg_bus_bridge.sv - self-checking bench for dbg_bus_bridge (vector table, corner sequences, random vs model)
module tb_dbg_bus_bridge;

  localparam logic [7:0] C_W = 8'h57, C_R = 8'h52, C_B = 8'h42;
  localparam logic [7:0] R_OK = 8'h2E, R_BAD = 8'h3F;

  typedef struct {
    logic [31:0] bytes;
    int          nb;
    logic [7:0]  rsp;
    int          we;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dbg_bus_bridge_if bus ();

  dbg_bus_bridge #(.READ_LATENCY(1), .TIMEOUT_CYCLES(100)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.master)
  );

  bit [7:0]   mem     [0:65535];
  bit [7:0]   ref_mem [0:65535];
  logic [7:0] di_q;
  bit         rand_mode = 1'b0;
  logic       gnt_val = 1'b1;
  logic       rdy_val = 1'b1;
  logic [7:0] rsp_q[$];
  logic [23:0] we_log[$];
  int         we_cnt = 0;
  int         total = 0;
  int         bad = 0;

  always @(posedge clk) begin
    if (bus.WE) mem[bus.AB] <= bus.DO;
    di_q <= mem[bus.AB];
  end
  assign bus.DI = di_q;

  always begin
    if (rand_mode) begin
      bus.bus_gnt  = ($urandom_range(0, 3) != 0);
      bus.tx_ready = ($urandom_range(0, 2) != 0);
    end else begin
      bus.bus_gnt  = gnt_val;
      bus.tx_ready = rdy_val;
    end
    @(posedge clk);
    #2;
  end

  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready) rsp_q.push_back(bus.tx_data);
    if (bus.WE) begin
      we_cnt++;
      we_log.push_back({bus.AB, bus.DO});
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #2;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #2;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      if (rsp_q.size() >= target && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s timeout: responses=%0d required %0d busy=%0d", name, rsp_q.size(), target, bus.busy);
    end
  endtask

  task automatic run_vec(input logic [31:0] bytes, input int nb, input logic [7:0] exp[$], input string name);
    int base;
    base = rsp_q.size();
    for (int j = 0; j < nb; j++) send_byte(bytes[31-8*j -: 8]);
    wait_idle(base + exp.size(), name);
    chk({name, " count"}, rsp_q.size() - base, exp.size());
    for (int j = 0; j < exp.size(); j++)
      if (base + j < rsp_q.size()) chk($sformatf("%s[%0d]", name, j), rsp_q[base+j], exp[j]);
  endtask

  initial begin
    vec_t        vt[10];
    logic [7:0]  eq[$];
    int          we0, base, n, drops, viol, exp_we;
    bit          ok;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    vt[0] = '{32'h571234A5, 4, R_OK,  1};
    vt[1] = '{32'h52123400, 3, 8'hA5, 0};
    vt[2] = '{32'h570F003C, 4, R_OK,  1};
    vt[3] = '{32'h520F0000, 3, 8'h3C, 0};
    vt[4] = '{32'h99000000, 1, R_BAD, 0};
    vt[5] = '{32'h52ABCD00, 3, 8'h00, 0};
    vt[6] = '{32'h00000000, 1, R_BAD, 0};
    vt[7] = '{32'h57FFFE11, 4, R_OK,  1};
    vt[8] = '{32'h57FFFF22, 4, R_OK,  1};
    vt[9] = '{32'h57000033, 4, R_OK,  1};

    repeat (3) @(negedge clk);
    chk("rst_ctl", {bus.tx_valid, bus.bus_req, bus.busy, bus.WE}, 0);
    chk("rst_ab", bus.AB, 0);
    chk("rst_do", bus.DO, 0);
    chk("rst_tx", bus.tx_data, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      we0 = we_cnt;
      eq.delete();
      eq.push_back(vt[i].rsp);
      run_vec(vt[i].bytes, vt[i].nb, eq, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d we", i), we_cnt - we0, vt[i].we);
      if (vt[i].we == 1) begin
        chk($sformatf("vec%0d we_ab_do", i), we_log[we_log.size()-1], vt[i].bytes[23:0]);
        ref_mem[vt[i].bytes[23:8]] = vt[i].bytes[7:0];
      end
    end
    chk("bus_req_after_write", bus.bus_req, 0);

    // block read across the 0xFFFF -> 0x0000 wrap with bus_req held between bytes
    base  = rsp_q.size();
    drops = 0;
    fork
      begin
        send_byte(C_B); send_byte(8'hFF); send_byte(8'hFE); send_byte(8'h02);
      end
      begin
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          #1;
          if (bus.bus_req) begin ok = 1'b1; break; end
        end
        for (int k = 0; k < 200 && ok; k++) begin
          @(negedge clk);
          #1;
          if (rsp_q.size() - base >= 2 && bus.tx_valid) break;
          if (!bus.bus_req) drops++;
        end
      end
    join
    wait_idle(base + 3, "blk");
    chk("blk count", rsp_q.size() - base, 3);
    chk("blk0", rsp_q[base], 8'h11);
    chk("blk1", rsp_q[base+1], 8'h22);
    chk("blk2", rsp_q[base+2], 8'h33);
    chk("blk req drops", drops, 0);

    // write latency: REQ with grant already high to WE
    n = -1;
    fork
      begin send_byte(C_W); send_byte(8'h30); send_byte(8'h00); send_byte(8'h77); end
      begin
        for (int k = 0; k < 200; k++) begin @(negedge clk); if (bus.bus_req) break; end
        for (int k = 1; k < 10; k++) begin @(negedge clk); if (bus.WE) begin n = k; break; end end
      end
    join
    wait_idle(rsp_q.size(), "wlat");
    chk("write latency", n, 1);
    ref_mem[16'h3000] = 8'h77;

    // read latency: AB valid to tx_valid
    n = -1;
    base = rsp_q.size();
    fork
      begin send_byte(C_R); send_byte(8'h30); send_byte(8'h00); end
      begin
        for (int k = 0; k < 200; k++) begin @(negedge clk); if (bus.bus_gnt && bus.AB == 16'h3000) break; end
        for (int k = 1; k < 10; k++) begin @(negedge clk); if (bus.tx_valid) begin n = k; break; end end
      end
    join
    wait_idle(base + 1, "rlat");
    chk("read latency", n, 2);
    chk("rlat data", rsp_q[base], 8'h77);

    // grant withheld, then transmitter backpressure
    gnt_val = 1'b0;
    rdy_val = 1'b0;
    we0  = we_cnt;
    base = rsp_q.size();
    send_byte(C_W); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin @(negedge clk); if (bus.bus_req) begin ok = 1'b1; break; end end
    chk("gnt req seen", ok, 1);
    viol = 0;
    repeat (10) begin @(negedge clk); if (bus.AB != 16'h0 || bus.WE || bus.DO != 8'h0) viol++; end
    chk("no bus without gnt", viol, 0);
    gnt_val = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin @(negedge clk); if (bus.tx_valid) begin ok = 1'b1; break; end end
    chk("bp tx_valid seen", ok, 1);
    viol = 0;
    repeat (5) begin @(negedge clk); if (!bus.tx_valid || bus.tx_data != R_OK) viol++; end
    chk("tx held", viol, 0);
    rdy_val = 1'b1;
    wait_idle(base + 1, "bp");
    chk("bp rsp", rsp_q[base], R_OK);
    chk("bp single WE", we_cnt - we0, 1);
    ref_mem[16'h4455] = 8'h66;

    // bad command never requests the bus
    viol = 0;
    base = rsp_q.size();
    fork
      send_byte(8'h99);
      repeat (20) begin @(negedge clk); if (bus.bus_req) viol++; end
    join
    chk("bad no req", viol, 0);
    chk("bad rsp", rsp_q[base], R_BAD);

    // byte arriving during RESP is dropped
    rdy_val = 1'b0;
    base = rsp_q.size();
    send_byte(C_R); send_byte(8'h0F); send_byte(8'h00);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin @(negedge clk); if (bus.tx_valid) begin ok = 1'b1; break; end end
    chk("drop tx_valid seen", ok, 1);
    send_byte(C_W);
    rdy_val = 1'b1;
    wait_idle(base + 1, "drop");
    chk("drop rsp", rsp_q[base], 8'h3C);
    eq.delete();
    eq.push_back(8'hA5);
    run_vec(32'h52123400, 3, eq, "after_drop");

    // partial command: timeout abort or indefinite wait
    we0  = we_cnt;
    base = rsp_q.size();
    send_byte(C_W); send_byte(8'h12);
    repeat (150) @(negedge clk);
`ifdef DBG_TIMEOUT_EN
    chk("tmo count", rsp_q.size() - base, 1);
    if (rsp_q.size() > base) chk("tmo rsp", rsp_q[base], 8'h21);
    chk("tmo idle", bus.busy, 0);
    chk("tmo no WE", we_cnt - we0, 0);
`else
    chk("partial busy", bus.busy, 1);
    chk("partial no rsp", rsp_q.size() - base, 0);
    send_byte(8'h34); send_byte(8'h5A);
    wait_idle(base + 1, "partial");
    chk("partial rsp", rsp_q[base], R_OK);
    ref_mem[16'h1234] = 8'h5A;
`endif

    // randomized commands with random grant and ready against the memory model
    rand_mode = 1'b1;
    we0    = we_cnt;
    exp_we = 0;
    for (int k = 0; k < 40; k++) begin
      int          op, nb, nn;
      logic [15:0] a;
      logic [7:0]  d;
      logic [31:0] by;
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 4) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                       : 16'h2000 + 16'($urandom_range(0, 7));
      eq.delete();
      case (op)
        0: begin
          d = 8'($urandom);
          by = {C_W, a, d}; nb = 4;
          ref_mem[a] = d;
          eq.push_back(R_OK);
          exp_we++;
        end
        1: begin
          by = {C_R, a, 8'h00}; nb = 3;
          eq.push_back(ref_mem[a]);
        end
        2: begin
          nn = $urandom_range(0, 3);
          by = {C_B, a, 8'(nn)}; nb = 4;
          for (int j = 0; j <= nn; j++) eq.push_back(ref_mem[16'(a + 16'(j))]);
        end
        default: begin
          do d = 8'($urandom); while (d == C_W || d == C_R || d == C_B);
          by = {d, 24'h0}; nb = 1;
          eq.push_back(R_BAD);
        end
      endcase
      run_vec(by, nb, eq, $sformatf("rand%0d", k));
    end
    rand_mode = 1'b0;
    chk("rand WE total", we_cnt - we0, exp_we);

    // asynchronous reset in the middle of a block
    rdy_val = 1'b0;
    base = rsp_q.size();
    send_byte(C_B); send_byte(8'h20); send_byte(8'h00); send_byte(8'h03);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin @(negedge clk); if (bus.tx_valid) begin ok = 1'b1; break; end end
    chk("blk rst tx_valid seen", ok, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst ctl", {bus.tx_valid, bus.bus_req, bus.busy, bus.WE}, 0);
    chk("arst ab", bus.AB, 0);
    chk("arst do_tx", {bus.DO, bus.tx_data}, 0);
    rdy_val = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst no partial rsp", rsp_q.size() - base, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    eq.delete();
    eq.push_back(ref_mem[16'h4455]);
    run_vec(32'h52445500, 3, eq, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
